// File: rtl/mr_exec_unit_if.sv
// Operation encoding shared by the execution unit, its interface and any
// requester. Encodings outside the listed values are undefined ops: they
// complete in one cycle with a zero result.
package mr_exec_pkg;
  typedef enum logic [4:0] {
    ALU_ADD     = 5'd0,
    ALU_SUB     = 5'd1,
    ALU_AND     = 5'd2,
    ALU_OR      = 5'd3,
    ALU_XOR     = 5'd4,
    ALU_SH_L    = 5'd5,
    ALU_SH_RL   = 5'd6,
    ALU_SH_RA   = 5'd7,
    ALU_CMP_LT  = 5'd8,
    ALU_CMP_LTU = 5'd9,
    ALU_MUL     = 5'd10,
    ALU_MULH    = 5'd11,
    ALU_MULHSU  = 5'd12,
    ALU_MULHU   = 5'd13,
    ALU_DIV     = 5'd14,
    ALU_DIVU    = 5'd15,
    ALU_REM     = 5'd16,
    ALU_REMU    = 5'd17
  } e_aluops;
endpackage

// mr_exec_unit_if: request/response bundle of the execution unit.
//   flush                 kill the in-flight op and the output register
//   in_valid/in_ready     request handshake; in_op, in_arg1/2, in_dest_reg payload
//   out_valid/out_ready   result handshake; out_result, out_dest_reg payload
//   busy                  a multi-cycle op is in progress
// master = requester/consumer side, slave = execution unit.
interface mr_exec_unit_if
  import mr_exec_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int REGSEL_BITS = 5
) ();
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  e_aluops                in_op;
  logic [XLEN-1:0]        in_arg1;
  logic [XLEN-1:0]        in_arg2;
  logic [REGSEL_BITS-1:0] in_dest_reg;
  logic                   out_valid;
  logic                   out_ready;
  logic [XLEN-1:0]        out_result;
  logic [REGSEL_BITS-1:0] out_dest_reg;
  logic                   busy;

  modport master (
    output flush, in_valid, in_op, in_arg1, in_arg2, in_dest_reg, out_ready,
    input  in_ready, out_valid, out_result, out_dest_reg, busy
  );

  modport slave (
    input  flush, in_valid, in_op, in_arg1, in_arg2, in_dest_reg, out_ready,
    output in_ready, out_valid, out_result, out_dest_reg, busy
  );
endinterface

// File: rtl/mr_exec_unit.sv
// mr_exec_unit: integer execution unit. Base ALU ops complete one cycle after
// acceptance at full rate; M-extension ops run on a shared 1-bit-per-cycle
// shift-add multiplier / restoring divider over operand magnitudes and
// complete exactly XLEN+1 cycles after acceptance.
//   clk, rst  clock and synchronous active-high reset
//   bus       mr_exec_unit_if.slave (request, result, flush, busy)
module mr_exec_unit
  import mr_exec_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int REGSEL_BITS = 5,
  parameter int HAS_MULDIV  = 1
) (
  input  logic          clk,
  input  logic          rst,
  mr_exec_unit_if.slave bus
);
  localparam int SHW = $clog2(XLEN);
  // The acceptance edge performs the first iteration, so the iterate state
  // runs XLEN-1 cycles and DONE lands on cycle XLEN.
  localparam logic [SHW-1:0] CNT_LAST = SHW'(XLEN - 2);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} e_state;

  e_state                 state;
  e_aluops                op_q;
  logic [XLEN-1:0]        hi, lo, opb, arg1_q;
  logic                   neg1, neg2, div0;
  logic [REGSEL_BITS-1:0] dest_q;
  logic [SHW-1:0]         cnt;
  logic                   ov;
  logic [XLEN-1:0]        ores;
  logic [REGSEL_BITS-1:0] odest;

  function automatic logic is_md(e_aluops op);
    return (HAS_MULDIV != 0) && (op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                                            ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU});
  endfunction

  function automatic logic is_div(e_aluops op);
    return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction

  // Operand signedness: MULHSU is signed x unsigned.
  function automatic logic sgn1(e_aluops op);
    return op inside {ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
  endfunction

  function automatic logic sgn2(e_aluops op);
    return op inside {ALU_MULH, ALU_DIV, ALU_REM};
  endfunction

  logic            idle, in_ready, accept, in_md, in_neg1, in_neg2;
  logic [XLEN-1:0] in_mag1, in_mag2;
  logic [SHW-1:0]  shamt;

  assign idle     = (state == IDLE);
  assign in_ready = !rst && idle && (!ov || bus.out_ready) && !bus.flush;
  assign accept   = bus.in_valid && in_ready;
  assign in_md    = is_md(bus.in_op);
  assign in_neg1  = sgn1(bus.in_op) && bus.in_arg1[XLEN-1];
  assign in_neg2  = sgn2(bus.in_op) && bus.in_arg2[XLEN-1];
  assign in_mag1  = in_neg1 ? -bus.in_arg1 : bus.in_arg1;
  assign in_mag2  = in_neg2 ? -bus.in_arg2 : bus.in_arg2;
  assign shamt    = bus.in_arg2[SHW-1:0];

  // Base ALU
  logic [XLEN-1:0] alu_res;
  always_comb begin
    alu_res = '0;
    case (bus.in_op)
      ALU_ADD:     alu_res = bus.in_arg1 + bus.in_arg2;
      ALU_SUB:     alu_res = bus.in_arg1 - bus.in_arg2;
      ALU_AND:     alu_res = bus.in_arg1 & bus.in_arg2;
      ALU_OR:      alu_res = bus.in_arg1 | bus.in_arg2;
      ALU_XOR:     alu_res = bus.in_arg1 ^ bus.in_arg2;
      ALU_SH_L:    alu_res = bus.in_arg1 << shamt;
      ALU_SH_RL:   alu_res = bus.in_arg1 >> shamt;
      ALU_SH_RA:   alu_res = $signed(bus.in_arg1) >>> shamt;
      ALU_CMP_LT:  alu_res = {{(XLEN-1){1'b0}}, $signed(bus.in_arg1) < $signed(bus.in_arg2)};
      ALU_CMP_LTU: alu_res = {{(XLEN-1){1'b0}}, bus.in_arg1 < bus.in_arg2};
      default:     alu_res = '0;
    endcase
  end

  // One shared iteration step. In IDLE it is fed from the incoming operands
  // so the acceptance edge already performs iteration 1.
  // mul: {hi,lo} = {partial product, multiplier}; opb = multiplicand
  // div: hi = partial remainder, lo = dividend in / quotient out; opb = divisor
  logic            s_div;
  logic [XLEN-1:0] s_hi, s_lo, s_opb, n_hi, n_lo;
  logic [XLEN:0]   m_sum, r_sh, d_diff;
  always_comb begin
    s_div  = idle ? is_div(bus.in_op) : (state == DIV);
    s_hi   = idle ? '0 : hi;
    s_lo   = idle ? in_mag1 : lo;
    s_opb  = idle ? in_mag2 : opb;
    m_sum  = {1'b0, s_hi} + (s_lo[0] ? {1'b0, s_opb} : '0);
    r_sh   = {s_hi, s_lo[XLEN-1]};
    d_diff = r_sh - {1'b0, s_opb};
    if (s_div) begin
      // Restore (keep shifted remainder) when the trial subtraction borrows.
      n_hi = d_diff[XLEN] ? r_sh[XLEN-1:0] : d_diff[XLEN-1:0];
      n_lo = {s_lo[XLEN-2:0], ~d_diff[XLEN]};
    end else begin
      n_hi = m_sum[XLEN:1];
      n_lo = {m_sum[0], s_lo[XLEN-1:1]};
    end
  end

  // Sign correction and corner cases, evaluated in DONE.
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   md_res;
  always_comb begin
    prod = (neg1 ^ neg2) ? -{hi, lo} : {hi, lo};
    case (op_q)
      ALU_MUL:                         md_res = prod[XLEN-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU: md_res = prod[2*XLEN-1:XLEN];
      ALU_DIV:  md_res = div0 ? '1 : ((neg1 ^ neg2) ? -lo : lo);
      ALU_DIVU: md_res = div0 ? '1 : lo;
      ALU_REM:  md_res = div0 ? arg1_q : (neg1 ? -hi : hi);
      ALU_REMU: md_res = div0 ? arg1_q : hi;
      default:  md_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ov    <= 1'b0;
      ores  <= '0;
      odest <= '0;
      cnt   <= '0;
    end else if (bus.flush) begin
      state <= IDLE;
      ov    <= 1'b0;
    end else begin
      if (ov && bus.out_ready) ov <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          if (in_md) begin
            state  <= is_div(bus.in_op) ? DIV : MUL;
            op_q   <= bus.in_op;
            dest_q <= bus.in_dest_reg;
            arg1_q <= bus.in_arg1;
            neg1   <= in_neg1;
            neg2   <= in_neg2;
            div0   <= (bus.in_arg2 == '0);
            opb    <= in_mag2;
            hi     <= n_hi;
            lo     <= n_lo;
            cnt    <= '0;
          end else begin
            ov    <= 1'b1;
            ores  <= alu_res;
            odest <= bus.in_dest_reg;
          end
        end
        MUL, DIV: begin
          hi  <= n_hi;
          lo  <= n_lo;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= DONE;
        end
        DONE: if (!ov || bus.out_ready) begin
          // Wait here while a previous result is still stalled.
          ov    <= 1'b1;
          ores  <= md_res;
          odest <= dest_q;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = ov;
  assign bus.out_result   = ores;
  assign bus.out_dest_reg = odest;
  assign bus.busy         = !idle;
endmodule

// File: tb/tb_mr_exec_unit.sv
// Directed-vector bench for mr_exec_unit (XLEN=32). Stimulus pushes the
// hand-computed result onto a scoreboard at acceptance; a monitor pops and
// compares on every output transfer.
module tb_mr_exec_unit;
  import mr_exec_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mr_exec_unit_if #(.XLEN(32), .REGSEL_BITS(5)) bus ();

  mr_exec_unit #(.XLEN(32), .REGSEL_BITS(5), .HAS_MULDIV(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [36:0] exp_q[$];   // {dest, result}

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every output transfer must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {bus.out_dest_reg, bus.out_result}, 37'h0);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        chk("sb_result", bus.out_result, e[31:0]);
        chk("sb_dest", bus.out_dest_reg, e[36:32]);
      end
    end
  end

  // Present a request and hold it until accepted (bounded); returns at
  // posedge+1 of the cycle after acceptance.
  task automatic send(input e_aluops op, input logic [31:0] a1, input logic [31:0] a2,
                      input logic [4:0] d, input logic [31:0] exp, input bit push);
    int t;
    t = 0;
    bus.in_valid = 1'b1; bus.in_op = op;
    bus.in_arg1 = a1; bus.in_arg2 = a2; bus.in_dest_reg = d;
    @(negedge clk);
    while (!bus.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("accept", bus.in_ready, 1);
    if (bus.in_ready && push) exp_q.push_back({d, exp});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(negedge clk);
    chk("drain", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    bit ok;
    rst = 1'b1;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_op = ALU_ADD;
    bus.in_arg1 = '0; bus.in_arg2 = '0; bus.in_dest_reg = '0; bus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_outputs", {bus.out_valid, bus.busy, bus.out_dest_reg, bus.out_result}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", bus.in_ready, 1);
    @(posedge clk); #1;

    // Back-to-back base ops
    send(ALU_ADD,   32'd5,        32'd7,  5'd1, 32'd12,       1);
    send(ALU_SUB,   32'd3,        32'd5,  5'd2, 32'hFFFFFFFE, 1);
    send(ALU_SH_RA, 32'h80000000, 32'h21, 5'd3, 32'hC0000000, 1);
    @(negedge clk);
    chk("b2b_third_cycle", {bus.out_valid, bus.out_result}, {1'b1, 32'hC0000000});
    @(posedge clk); #1;
    send(ALU_AND,     32'hF0F0F0F0, 32'h0FF00FF0, 5'd4,  32'h00F000F0, 1);
    send(ALU_OR,      32'hF0F0F0F0, 32'h0FF00FF0, 5'd5,  32'hFFF0FFF0, 1);
    send(ALU_XOR,     32'hF0F0F0F0, 32'h0FF00FF0, 5'd6,  32'hFF00FF00, 1);
    send(ALU_SH_L,    32'h1,        32'h3F,       5'd7,  32'h80000000, 1);
    send(ALU_SH_RL,   32'h80000000, 32'h4,        5'd8,  32'h08000000, 1);
    send(ALU_CMP_LT,  32'hFFFFFFFF, 32'h1,        5'd9,  32'h1,        1);
    send(ALU_CMP_LTU, 32'hFFFFFFFF, 32'h1,        5'd10, 32'h0,        1);
    send(e_aluops'(5'd30), 32'h1234, 32'h5678,    5'd11, 32'h0,        1);
    drain();

    // MULH timing, busy window, and operand latching
    send(ALU_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd12, 32'h0, 1);
    ok = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (!bus.busy || bus.out_valid) ok = 1'b0;
      bus.in_arg1 = $urandom; bus.in_arg2 = $urandom;
    end
    chk("mulh_busy_window", ok, 1);
    @(negedge clk);
    chk("mulh_valid_at_33", {bus.out_valid, bus.busy}, 2'b10);
    @(posedge clk); #1;
    send(ALU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd13, 32'hFFFFFFFE, 1);
    send(ALU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd14, 32'hFFFFFFFF, 1);
    send(ALU_MUL,    32'hFFFFFFFD, 32'd5,        5'd15, 32'hFFFFFFF1, 1);

    // Division corners
    send(ALU_DIV,  32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h80000000, 1);
    send(ALU_REM,  32'h80000000, 32'hFFFFFFFF, 5'd17, 32'h0,        1);
    send(ALU_DIVU, 32'd9,        32'd0,        5'd18, 32'hFFFFFFFF, 1);
    send(ALU_REMU, 32'd9,        32'd0,        5'd19, 32'd9,        1);
    send(ALU_REM,  32'hFFFFFFF9, 32'd2,        5'd20, 32'hFFFFFFFF, 1);
    send(ALU_DIV,  32'hFFFFFFF9, 32'd2,        5'd21, 32'hFFFFFFFD, 1);
    send(ALU_DIV,  32'hFFFFFFF9, 32'd0,        5'd22, 32'hFFFFFFFF, 1);
    send(ALU_REM,  32'hFFFFFFF9, 32'd0,        5'd23, 32'hFFFFFFF9, 1);
    send(ALU_DIVU, 32'd100,      32'd7,        5'd24, 32'd14,       1);
    send(ALU_REMU, 32'd100,      32'd7,        5'd25, 32'd2,        1);
    drain();

    // Backpressure
    bus.out_ready = 1'b0;
    send(ALU_ADD, 32'd1, 32'd1, 5'd2, 32'd2, 1);
    bus.in_valid = 1'b1; bus.in_op = ALU_ADD;
    bus.in_arg1 = 32'd3; bus.in_arg2 = 32'd4; bus.in_dest_reg = 5'd9;
    ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (!bus.out_valid || bus.out_result !== 32'd2 || bus.out_dest_reg !== 5'd2 || bus.in_ready)
        ok = 1'b0;
    end
    chk("stall_stable", ok, 1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("accept_on_ready_rise", bus.in_ready, 1);
    if (bus.in_ready) exp_q.push_back({5'd9, 32'd7});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    drain();

    // Flush during DIVU
    send(ALU_DIVU, 32'd100, 32'd7, 5'd3, 32'd14, 0);
    repeat (9) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    bus.in_valid = 1'b1; bus.in_op = ALU_ADD;
    bus.in_arg1 = 32'd20; bus.in_arg2 = 32'd22; bus.in_dest_reg = 5'd4;
    @(negedge clk);
    chk("flush_cycle", {bus.in_ready, bus.busy}, 2'b01);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    chk("after_flush", {bus.busy, bus.out_valid, bus.in_ready}, 3'b001);
    if (bus.in_ready) exp_q.push_back({5'd4, 32'd42});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (40) @(negedge clk);
    drain();

    // Reset in the middle of a MUL
    send(ALU_MUL, 32'd6, 32'd7, 5'd5, 32'd42, 0);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("after_mid_rst", {bus.in_ready, bus.busy, bus.out_valid}, 3'b100);
    repeat (40) @(negedge clk);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mr_exec_unit.md
MR_EXEC_UNIT -- requirements
Module: mr_exec_unit

Interface
REQ-001 SHALL provide parameter XLEN, default 32, datapath width; legal values are 32 and 64.
REQ-002 SHALL provide parameter REGSEL_BITS, default 5, destination register selector width.
REQ-003 SHALL provide parameter HAS_MULDIV, default 1; when set to 1 the M-extension ops are enabled, and when set to 0 those ops produce result 0 with single-cycle latency.
REQ-004 SHALL provide these ports, in order:
- clk  in  1  clock; one clock domain, all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  synchronous kill of the in-flight op and the output.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request this cycle.
- in_op  in  e_aluops  operation; ALU_* base ops plus ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU.
- in_arg1  in  XLEN  operand 1.
- in_arg2  in  XLEN  operand 2.
- in_dest_reg  in  REGSEL_BITS  destination register tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  XLEN  result.
- out_dest_reg  out  REGSEL_BITS  tag of the result.
- busy  out  1  a multi-cycle op is in progress.

Function
REQ-005 SHALL accept a request on a cycle where in_valid and in_ready are both high.
REQ-006 SHALL drive in_ready = (state==IDLE) and (out_valid==0 or out_ready==1) and flush==0.
REQ-007 SHALL hold out_valid, out_result and out_dest_reg stable while out_valid=1 and out_ready=0.
REQ-008 SHALL complete each result transfer on a cycle where out_valid and out_ready are both high; if no new result is loaded that cycle, out_valid SHALL go to 0 on the next cycle.
REQ-009 SHALL produce base ops (ADD, SUB, AND, OR, XOR, SH_L, SH_RL, SH_RA, CMP_LT, CMP_LTU) with out_valid 1 cycle after acceptance, supporting back-to-back issue at full rate.
REQ-010 SHALL use only shift amount in_arg2[$clog2(XLEN)-1:0]; SH_RA SHALL sign-fill.
REQ-011 SHALL zero-extend CMP results to XLEN, with the compare result in bit 0.
REQ-012 SHALL implement this state machine:
- IDLE -> MUL or DIV when a muldiv op is accepted.
- MUL/DIV -> DONE after XLEN iteration cycles.
- DONE -> IDLE when the result is loaded into the output register.
REQ-013 SHALL run an iterative multiplier that computes 1 bit per cycle and produces the full 2*XLEN product internally.
REQ-014 SHALL return the low XLEN bits of the product for MUL and the high XLEN bits for MULH, MULHSU and MULHU.
REQ-015 SHALL perform MULHSU as signed-arg1 times unsigned-arg2.
REQ-016 SHALL run an iterative restoring divider over operand magnitudes, with sign correction applied in DONE.
REQ-017 SHALL set the remainder sign equal to the dividend sign for REM.
REQ-018 SHALL produce muldiv results with out_valid exactly XLEN+1 cycles after acceptance, independent of operand values.
REQ-019 SHALL handle divide by zero with quotient all-ones, remainder = arg1, and no exception.
REQ-020 SHALL handle signed overflow (arg1 = -2^(XLEN-1), arg2 = -1) with DIV = arg1 and REM = 0.
REQ-021 SHALL keep busy high in the MUL, DIV and DONE states and low otherwise.
REQ-022 SHALL latch operands and dest_reg at acceptance; input changes during BUSY SHALL have no effect.
REQ-023 SHALL, on flush, force the state to IDLE and out_valid to 0 on the next cycle and discard the in-flight op.
REQ-024 SHALL accept no request on a flush cycle, because in_ready is 0 on that cycle.
REQ-025 SHALL stay in DONE with in_ready=0 when the prior result is stalled (out_valid=1, out_ready=0) at the point DONE is reached.
REQ-026 SHALL return out_result=0 for any undefined op, with single-cycle latency.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, set state=IDLE, out_valid=0, busy=0, out_result=0 and out_dest_reg=0.
REQ-028 SHALL drive in_ready=0 during reset and in_ready=1 on the first cycle after reset deasserts.
REQ-029 SHALL, on reset mid-operation, abandon the operation with no output produced.
REQ-030 SHALL give reset priority over flush and over every handshake.

Verification
REQ-031 SHALL cover back-to-back base ops: ADD 5+7, SUB 3-5, SH_RA 0x80000000 by 0x21 (XLEN=32), each cycle with out_ready=1 -> results 12, 0xFFFFFFFE, 0xC0000000 on three consecutive cycles.
REQ-032 SHALL cover MULH: arg1=0xFFFFFFFF, arg2=0xFFFFFFFF -> 0x00000000 at cycle +33; MULHU with the same operands -> 0xFFFFFFFE; busy high for cycles +1..+32.
REQ-033 SHALL cover division corners: DIV 0x80000000 by 0xFFFFFFFF -> 0x80000000; REM on the same operands -> 0; DIVU 9 by 0 -> 0xFFFFFFFF; REMU 9 by 0 -> 9; REM -7 by 2 -> -1.
REQ-034 SHALL cover backpressure: hold out_ready=0 for 5 cycles after ADD 1+1 -> out_result=2 stable, in_ready=0 throughout; a second request is accepted on the cycle out_ready rises.
REQ-035 SHALL cover flush: issue DIVU, pulse flush at cycle +10 -> no out_valid, busy=0 at +11, and a new ADD is accepted at +11.
REQ-036 SHALL cover reset mid-MUL: rst at cycle +5 for 1 cycle -> out_valid never rises for that MUL, in_ready=1 on the cycle after reset releases.
